// File: rtl/pe_output_tracker.sv
// pe_output_tracker
//   Tracks completion of output-stationary systolic-array blocks. Each PE
//   has one tracker slot. A block accepted at PE(0,0) travels across the
//   array as a diagonal wavefront. Every PE counts down its MAC cycles and
//   raises out_valid, with the block's absolute row, column and channel, in
//   its last MAC cycle. Several blocks can be in flight at the same time.
//
//   Optional feature: define PE_OUTPUT_TRACKER_BOUNDS_MASK_EN to gate each
//   out_valid with (base_row+i < out_rows) && (base_col+j < out_cols). When
//   it is undefined, out_rows and out_cols are ignored and writeback clips.
//
// Ports
//   clk, reset_n              clock; asynchronous active-low reset
//   mat_size                  reduction length (stable while busy)
//   out_rows, out_cols        layer output extent (bounds mask only)
//   input_valid / in_ready    block injection handshake at PE(0,0)
//   stall                     freezes all tracker state
//   pos_row, pos_col, channel block base coordinate and output channel
//   out_valid[k]              PE k result valid, k = i*COLS+j
//   out_row/out_col/out_channel[k]  absolute coordinate of PE k's block
//   busy                      any PE active

// Per-PE tracker slot: start pulse, active flag, countdown and block base.
module pe_output_tracker_pe #(
  parameter int N_BITS  = 10,
  parameter int CH_BITS = 7,
  parameter int CT_BITS = 8,
  parameter int ROW_IDX = 0,
  parameter int COL_IDX = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               start_in,
  input  logic [CT_BITS-1:0] c_load,
  input  logic [N_BITS-1:0]  src_row,
  input  logic [N_BITS-1:0]  src_col,
  input  logic [CH_BITS-1:0] src_ch,
  input  logic [N_BITS-1:0]  out_rows,
  input  logic [N_BITS-1:0]  out_cols,
  output logic               active,
  output logic               start,
  output logic               cnt_zero,
  output logic [N_BITS-1:0]  base_row,
  output logic [N_BITS-1:0]  base_col,
  output logic [CH_BITS-1:0] base_ch,
  output logic               out_valid,
  output logic [N_BITS-1:0]  out_row,
  output logic [N_BITS-1:0]  out_col,
  output logic [CH_BITS-1:0] out_channel
);
  localparam int NB1 = N_BITS + 1;
  localparam logic [N_BITS-1:0] ROW_OFF = N_BITS'(ROW_IDX);
  localparam logic [N_BITS-1:0] COL_OFF = N_BITS'(COL_IDX);

  logic [CT_BITS-1:0] count;
  logic               in_bounds;

  // A start landing on the same edge as the final cycle takes priority over
  // retiring the old block, which is what makes back-to-back blocks work.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active   <= 1'b0;
      start    <= 1'b0;
      count    <= '0;
      base_row <= '0;
      base_col <= '0;
      base_ch  <= '0;
    end else if (!stall) begin
      start <= start_in;
      if (start_in) begin
        active   <= 1'b1;
        count    <= c_load;
        base_row <= src_row;
        base_col <= src_col;
        base_ch  <= src_ch;
      end else if (active) begin
        if (count != '0) count <= count - CT_BITS'(1);
        else             active <= 1'b0;
      end
    end
  end

  assign cnt_zero = (count == '0);

`ifdef PE_OUTPUT_TRACKER_BOUNDS_MASK_EN
  // Compare at one extra bit so a coordinate that wraps past 2^N_BITS is
  // still seen as out of range.
  logic [NB1-1:0] row_abs, col_abs;
  assign row_abs   = {1'b0, base_row} + NB1'(ROW_IDX);
  assign col_abs   = {1'b0, base_col} + NB1'(COL_IDX);
  assign in_bounds = (row_abs < {1'b0, out_rows}) && (col_abs < {1'b0, out_cols});
`else
  logic unused_bounds;
  assign unused_bounds = ^{out_rows, out_cols};
  assign in_bounds     = 1'b1;
`endif

  assign out_valid   = active && cnt_zero && !stall && in_bounds;
  // Coordinates read as zero while the slot is idle.
  assign out_row     = active ? base_row + ROW_OFF : '0;
  assign out_col     = active ? base_col + COL_OFF : '0;
  assign out_channel = active ? base_ch : '0;
endmodule

module pe_output_tracker #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int NUM_CH         = 64,
  parameter int MAX_N          = 512,
  parameter int MACS_PER_CYCLE = 4,
  parameter int CH_BITS        = $clog2(NUM_CH + 1),
  parameter int N_BITS         = $clog2(MAX_N + 1),
  parameter int CT_BITS        = $clog2((MAX_N + MACS_PER_CYCLE - 1) / MACS_PER_CYCLE + 1)
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [N_BITS-1:0]                   mat_size,
  input  logic [N_BITS-1:0]                   out_rows,
  input  logic [N_BITS-1:0]                   out_cols,
  input  logic                                input_valid,
  output logic                                in_ready,
  input  logic                                stall,
  input  logic [N_BITS-1:0]                   pos_row,
  input  logic [N_BITS-1:0]                   pos_col,
  input  logic [CH_BITS-1:0]                  channel,
  output logic [ROWS*COLS-1:0]                out_valid,
  output logic [ROWS*COLS-1:0][N_BITS-1:0]    out_row,
  output logic [ROWS*COLS-1:0][N_BITS-1:0]    out_col,
  output logic [ROWS*COLS-1:0][CH_BITS-1:0]   out_channel,
  output logic                                busy
);
  localparam int NPE      = ROWS * COLS;
  localparam int NB1      = N_BITS + 1;
  localparam int LOG2_MPC = $clog2(MACS_PER_CYCLE);

  logic [NB1-1:0]                c_raw;
  logic [CT_BITS-1:0]            c_load;
  logic                          accept;
  logic [NPE-1:0]                active, start, cnt_zero, start_in;
  logic [NPE-1:0][N_BITS-1:0]    base_row, base_col, src_row, src_col;
  logic [NPE-1:0][CH_BITS-1:0]   base_ch, src_ch;

  // Counter load value is C-1, where C = max(1, ceil(mat_size/MACS_PER_CYCLE)).
  assign c_raw  = ({1'b0, mat_size} + NB1'(MACS_PER_CYCLE - 1)) >> LOG2_MPC;
  assign c_load = (c_raw == '0) ? '0 : CT_BITS'(c_raw - NB1'(1));

  // PE(0,0) can take a new block in its final cycle. With a fixed mat_size,
  // every downstream PE is already free by the time the wavefront gets there.
  assign in_ready = !stall && (!active[0] || cnt_zero[0]);
  assign accept   = input_valid && in_ready;
  assign busy     = |active;

  for (genvar k = 0; k < NPE; k++) begin : g_pe
    localparam int I = k / COLS;
    localparam int J = k % COLS;

    // Column 0 is fed from the PE above it. Every other PE is fed from its
    // left neighbour. The registered start pulse carries the wavefront.
    if (k == 0) begin : g_src
      assign start_in[k] = accept;
      assign src_row[k]  = pos_row;
      assign src_col[k]  = pos_col;
      assign src_ch[k]   = channel;
    end else if (J == 0) begin : g_src
      assign start_in[k] = start[k-COLS];
      assign src_row[k]  = base_row[k-COLS];
      assign src_col[k]  = base_col[k-COLS];
      assign src_ch[k]   = base_ch[k-COLS];
    end else begin : g_src
      assign start_in[k] = start[k-1];
      assign src_row[k]  = base_row[k-1];
      assign src_col[k]  = base_col[k-1];
      assign src_ch[k]   = base_ch[k-1];
    end

    pe_output_tracker_pe #(
      .N_BITS  (N_BITS),
      .CH_BITS (CH_BITS),
      .CT_BITS (CT_BITS),
      .ROW_IDX (I),
      .COL_IDX (J)
    ) u_pe (
      .clk         (clk),
      .reset_n     (reset_n),
      .stall       (stall),
      .start_in    (start_in[k]),
      .c_load      (c_load),
      .src_row     (src_row[k]),
      .src_col     (src_col[k]),
      .src_ch      (src_ch[k]),
      .out_rows    (out_rows),
      .out_cols    (out_cols),
      .active      (active[k]),
      .start       (start[k]),
      .cnt_zero    (cnt_zero[k]),
      .base_row    (base_row[k]),
      .base_col    (base_col[k]),
      .base_ch     (base_ch[k]),
      .out_valid   (out_valid[k]),
      .out_row     (out_row[k]),
      .out_col     (out_col[k]),
      .out_channel (out_channel[k])
    );
  end

`ifndef SYNTHESIS
  // Downstream PEs load C from mat_size as the wavefront arrives, so the
  // value must not move while any block is in flight.
  a_mat_size_stable: assert property (@(posedge clk) disable iff (!reset_n)
    busy |-> $stable(mat_size));
`endif
endmodule

// File: tb/tb_pe_output_tracker.sv
module tb_pe_output_tracker;
  localparam int ROWS = 4, COLS = 4, NUM_CH = 64, MAX_N = 512, MPC = 4;
  localparam int N_BITS  = $clog2(MAX_N + 1);
  localparam int CH_BITS = $clog2(NUM_CH + 1);
  localparam int NPE     = ROWS * COLS;
  localparam int NMASK   = (1 << N_BITS) - 1;
`ifdef PE_OUTPUT_TRACKER_BOUNDS_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic                            clk = 1'b0;
  logic                            reset_n = 1'b0;
  logic [N_BITS-1:0]               mat_size = '0, out_rows = '1, out_cols = '1;
  logic                            input_valid = 1'b0, stall = 1'b0;
  logic [N_BITS-1:0]               pos_row = '0, pos_col = '0;
  logic [CH_BITS-1:0]              channel = '0;
  logic                            in_ready, busy;
  logic [NPE-1:0]                  out_valid;
  logic [NPE-1:0][N_BITS-1:0]      out_row, out_col;
  logic [NPE-1:0][CH_BITS-1:0]     out_channel;

  always #5 clk = ~clk;

  pe_output_tracker dut (
    .clk(clk), .reset_n(reset_n), .mat_size(mat_size), .out_rows(out_rows),
    .out_cols(out_cols), .input_valid(input_valid), .in_ready(in_ready),
    .stall(stall), .pos_row(pos_row), .pos_col(pos_col), .channel(channel),
    .out_valid(out_valid), .out_row(out_row), .out_col(out_col),
    .out_channel(out_channel), .busy(busy)
  );

  // Reference model: a list of accepted blocks. Each block records the
  // unstalled cycle index at which it was accepted. PE(i,j) is active in
  // cycles e+1+i+j .. e+C+i+j and emits its result in the last of them.
  typedef struct { int e; int c; int row; int col; int ch; } blk_t;
  blk_t blks[$];
  int   tcnt;
  int   n_chk = 0, n_err = 0;
  logic [NPE-1:0]              ov_s;
  logic                        bz_s, rdy_s;
  logic [NPE-1:0][N_BITS-1:0]  row_s, col_s;
  logic [NPE-1:0][CH_BITS-1:0] ch_s;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int c_of(int ms);
    int c;
    c = (ms + MPC - 1) / MPC;
    return (c < 1) ? 1 : c;
  endfunction

  function automatic bit m_pe00_mid();
    foreach (blks[b])
      if (tcnt >= blks[b].e + 1 && tcnt <= blks[b].e + blks[b].c - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_busy();
    foreach (blks[b])
      if (tcnt >= blks[b].e + 1 && tcnt <= blks[b].e + blks[b].c + ROWS + COLS - 2) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit inb(int row, int col, int i, int j);
    return !MASK_EN || ((row + i < int'(out_rows)) && (col + j < int'(out_cols)));
  endfunction

  // One clock cycle: drive the inputs, check at the negedge, then advance the
  // model on the posedge.
  task automatic step(input bit iv, input bit st);
    logic [NPE-1:0] eov;
    input_valid = iv;
    stall       = st;
    @(negedge clk);
    ov_s = out_valid; bz_s = busy; rdy_s = in_ready;
    row_s = out_row; col_s = out_col; ch_s = out_channel;
    eov = '0;
    for (int k = 0; k < NPE; k++) begin
      int i, j;
      i = k / COLS;
      j = k % COLS;
      foreach (blks[b]) begin
        if (tcnt >= blks[b].e + 1 + i + j && tcnt <= blks[b].e + blks[b].c + i + j) begin
          chk($sformatf("row%0d", k), 64'(row_s[k]), 64'((blks[b].row + i) & NMASK));
          chk($sformatf("col%0d", k), 64'(col_s[k]), 64'((blks[b].col + j) & NMASK));
          chk($sformatf("ch%0d", k),  64'(ch_s[k]),  64'(blks[b].ch));
          if (!st && tcnt == blks[b].e + blks[b].c + i + j && inb(blks[b].row, blks[b].col, i, j))
            eov[k] = 1'b1;
        end
      end
    end
    chk("ov",   64'(ov_s),  64'(eov));
    chk("busy", 64'(bz_s),  64'(m_busy()));
    chk("rdy",  64'(rdy_s), 64'(!st && !m_pe00_mid()));
    @(posedge clk);
    if (!st) begin
      if (iv && !m_pe00_mid())
        blks.push_back('{tcnt, c_of(int'(mat_size)), int'(pos_row), int'(pos_col), int'(channel)});
      tcnt++;
      while (blks.size() > 0 && tcnt > blks[0].e + blks[0].c + ROWS + COLS - 2) void'(blks.pop_front());
    end
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && m_busy(); n++) step(1'b0, 1'b0);
  endtask

  initial begin
    int f00, f33, n0, n6;
    logic [NPE-1:0] acc, exp_acc;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov",   64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_coord", 64'(|{out_row, out_col, out_channel}), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_rdy", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    tcnt = 0;
    blks.delete();

    // C=3, single block (8,12,ch5)
    mat_size = 10'd9; pos_row = 10'd8; pos_col = 10'd12; channel = 7'd5;
    step(1'b1, 1'b0);
    f00 = -1; f33 = -1;
    for (int c = 1; c <= 10; c++) begin
      step(1'b0, 1'b0);
      if (ov_s[0] && f00 < 0) f00 = c;
      if (ov_s[15] && f33 < 0) begin
        f33 = c;
        chk("t1_row33", 64'(row_s[15]), 64'(11));
        chk("t1_col33", 64'(col_s[15]), 64'(15));
        chk("t1_ch33",  64'(ch_s[15]),  64'(5));
      end
      if (c == 9)  chk("t1_busy9",  64'(bz_s), 64'(1));
      if (c == 10) chk("t1_busy10", 64'(bz_s), 64'(0));
    end
    chk("t1_pe00_cyc", 64'(f00), 64'(3));
    chk("t1_pe33_cyc", 64'(f33), 64'(9));
    drain();

    // C=1, four blocks back to back
    mat_size = 10'd3;
    n0 = 0; n6 = 0;
    for (int c = 0; c <= 10; c++) begin
      pos_row = 10'(20 + c); pos_col = 10'(40 + c); channel = 7'(c);
      step(c < 4, 1'b0);
      if (c < 4) chk("t2_rdy", 64'(rdy_s), 64'(1));
      if (ov_s[0]) n0++;
      if (ov_s[6]) n6++;
      if (c >= 4 && c <= 7) chk("t2_pe12", 64'(ov_s[6]), 64'(1));
    end
    chk("t2_n00", 64'(n0), 64'(4));
    chk("t2_n12", 64'(n6), 64'(4));
    drain();

    // C=3, input_valid held: second accept in PE(0,0)'s final cycle
    mat_size = 10'd9;
    for (int c = 0; c <= 8; c++) begin
      pos_row = 10'(c); pos_col = 10'(100 + c);
      step(c <= 3, 1'b0);
      if (c == 1 || c == 2) chk("t3_rdy_lo", 64'(rdy_s), 64'(0));
      if (c == 3) chk("t3_rdy_hi", 64'(rdy_s), 64'(1));
      if (c == 6) chk("t3_pe00_c6", 64'(ov_s[0]), 64'(1));
      if (c == 5) chk("t3_pe00_c5", 64'(ov_s[0]), 64'(0));
    end
    drain();

    // C=3, stall in cycles 2-3
    f00 = -1; f33 = -1;
    for (int c = 0; c <= 13; c++) begin
      step(c == 0, c == 2 || c == 3);
      if (c == 2 || c == 3) chk("t4_stall_ov", 64'(ov_s), 64'(0));
      if (ov_s[0] && f00 < 0) f00 = c;
      if (ov_s[15] && f33 < 0) f33 = c;
    end
    chk("t4_pe00_cyc", 64'(f00), 64'(5));
    chk("t4_pe33_cyc", 64'(f33), 64'(11));
    drain();

    // C=8, reset in cycle 4
    mat_size = 10'd32;
    for (int c = 0; c <= 3; c++) step(c == 0, 1'b0);
    chk("t5_busy_pre", 64'(busy), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("t5_rst_ov",   64'(out_valid), 64'(0));
    chk("t5_rst_busy", 64'(busy), 64'(0));
    blks.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    tcnt = 0;
    acc = '0;
    for (int c = 0; c < 12; c++) begin
      step(1'b0, 1'b0);
      acc |= ov_s;
    end
    chk("t5_post_ov", 64'(acc), 64'(0));

    // Bounds: out_rows=10, out_cols=16, block (8,12), C=2
    mat_size = 10'd8; out_rows = 10'd10; out_cols = 10'd16;
    pos_row = 10'd8; pos_col = 10'd12; channel = 7'd9;
    acc = '0;
    for (int c = 0; c <= 10; c++) begin
      step(c == 0, 1'b0);
      acc |= ov_s;
    end
    exp_acc = MASK_EN ? 16'h00FF : 16'hFFFF;
    chk("t6_bounds", 64'(acc), 64'(exp_acc));
    drain();

    // Randomised episodes; mat_size only changes once the array is idle.
    for (int ep = 0; ep < 8; ep++) begin
      drain();
      mat_size = (ep % 4 == 3) ? 10'($urandom_range(0, MAX_N)) : 10'($urandom_range(0, 24));
      out_rows = 10'($urandom_range(0, 1023));
      out_cols = 10'($urandom_range(0, 1023));
      for (int c = 0; c < 60; c++) begin
        pos_row = 10'($urandom_range(0, 1023));
        pos_col = 10'($urandom_range(0, 1023));
        channel = 7'($urandom_range(0, NUM_CH - 1));
        step($urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0);
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
